// File: rtl/cl_crc_hw_pkg.sv
// Shared definitions for the hardware CRC arbiter slice.
// Holds the arbiter FSM state type, the CRC-32/IEEE constants
// (polynomial, init, xorout and the "123456789" check value) and a
// 32-bit bit-reversal helper.
package cl_crc_hw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_CHECK  = 32'hCBF43926;

  function automatic logic [31:0] reflect(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = v;
    for (int unsigned i = 0; i < 32; i++) begin
      r = {r[30:0], s[0]};
      s = s >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cl_crc_arbiter_step.sv
// Combinational single-beat CRC update: crc_out = f(crc_in, data).
// Ports:
//   crc_in  - CRC register before the beat (normal, non-reflected form)
//   data    - one beat, DATA_W/8 bytes
//   crc_out - CRC register after the beat
// With REFLECT set, bytes are taken LSB-first and each byte's bits are
// fed LSB-first, which matches the reflected CRC-32/IEEE convention
// while the register itself stays in normal (left-shifting) form.
module cl_crc_step #(
  parameter int unsigned          DATA_W  = 8,
  parameter int unsigned          CRC_W   = 32,
  parameter logic [CRC_W-1:0]     POLY    = 32'h04C11DB7,
  parameter bit                   REFLECT = 1'b1
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  localparam int unsigned NB = DATA_W / 8;

  logic [CRC_W-1:0]  c;
  logic [DATA_W-1:0] work;
  logic [7:0]        byte_v;
  logic              bit_in;
  logic              fb;

  // Bytes and bits are consumed by shifting rather than variable
  // indexing so the unrolled network stays a plain XOR tree.
  always_comb begin
    c      = crc_in;
    work   = data;
    byte_v = '0;
    bit_in = 1'b0;
    fb     = 1'b0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (REFLECT) begin
        byte_v = work[7:0];
        work   = work >> 8;
      end else begin
        byte_v = work[DATA_W-1 -: 8];
        work   = work << 8;
      end
      for (int unsigned i = 0; i < 8; i++) begin
        if (REFLECT) begin
          bit_in = byte_v[0];
          byte_v = byte_v >> 1;
        end else begin
          bit_in = byte_v[7];
          byte_v = byte_v << 1;
        end
        fb = c[CRC_W-1] ^ bit_in;
        c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/cl_crc_arbiter.sv
// Round-robin arbiter sharing one CRC engine between NUM_REQ streaming
// requesters. Arbitration only happens between frames; the grant is
// held (including across bubbles) until the granted requester's last
// beat is accepted, then one result is presented.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/ready/last  - per-requester beat handshake (ready one-hot)
//   req_data              - requester i data at [i*DATA_W +: DATA_W]
//   res_valid/ready       - result handshake
//   res_crc/id/beats      - finalised CRC, owning requester, beat count
//   busy                  - FSM not in IDLE
module cl_crc_arbiter
  import cl_crc_hw_pkg::*;
#(
  parameter int unsigned      NUM_REQ = 4,
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = CRC32_POLY,
  parameter logic [CRC_W-1:0] INIT    = CRC32_INIT,
  parameter logic [CRC_W-1:0] XOROUT  = CRC32_XOROUT,
  parameter bit               REFLECT = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [CRC_W-1:0]            res_crc,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] res_id,
  output logic [15:0]                 res_beats,
  output logic                        busy
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t            state;
  logic [ID_W-1:0]   gnt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   gnt_inc;
  logic              pick_found;
  logic [CRC_W-1:0]  crc_reg;
  logic [CRC_W-1:0]  crc_next;
  logic [CRC_W-1:0]  crc_final;
  logic [15:0]       beats;
  logic [15:0]       beats_inc;
  logic [DATA_W-1:0] gnt_data;
  logic              xfer;

  assign gnt_data  = req_data[int'(gnt)*DATA_W +: DATA_W];
  assign xfer      = (state == BUSY) && req_valid[gnt];
  assign beats_inc = (beats == 16'hFFFF) ? beats : beats + 16'd1;
  assign gnt_inc   = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
  assign busy      = (state != IDLE);

  cl_crc_step #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .REFLECT(REFLECT)
  ) u_step (
    .crc_in (crc_reg),
    .data   (gnt_data),
    .crc_out(crc_next)
  );

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid[ID_W'(idx)]) begin
        pick_found = 1'b1;
        pick       = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == BUSY) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    logic [CRC_W-1:0] s;
    logic [CRC_W-1:0] r;
    s = crc_next;
    r = '0;
    for (int unsigned i = 0; i < CRC_W; i++) begin
      r = {r[CRC_W-2:0], s[0]};
      s = s >> 1;
    end
    crc_final = (REFLECT ? r : crc_next) ^ XOROUT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      crc_reg   <= INIT;
      beats     <= '0;
      res_valid <= 1'b0;
      res_crc   <= '0;
      res_id    <= '0;
      res_beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt     <= pick;
            crc_reg <= INIT;
            beats   <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            crc_reg <= crc_next;
            beats   <= beats_inc;
            if (req_last[gnt]) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_crc   <= crc_final;
              res_id    <= gnt;
              res_beats <= beats_inc;
              rr_ptr    <= gnt_inc;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cl_crc_arbiter.md
Name: cl_crc_arbiter

Overview:
Shares one CRC engine between NUM_REQ streaming requesters. Arbitration is round-robin and happens on frame boundaries only; the grant is held until the granted requester's last beat is accepted. Each completed frame produces one result carrying the finalised CRC, the requester id and the beat count. This is the synthesizable companion to the library's CRC model, used where several packet sources need FCS generation/checking but only one engine is affordable.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, bits per beat (multiple of 8)
CRC_W, 32, CRC width
POLY, 32'h04C11DB7, generator polynomial (normal form)
INIT, 32'hFFFFFFFF, CRC register value at frame start
XOROUT, 32'hFFFFFFFF, value XORed into the final CRC
REFLECT, 1, 1 = reflect input bytes and output CRC (CRC-32/IEEE)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accept; at most one bit set
req_data  in  NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  final beat of frame
res_valid  out  1  result available
res_ready  in  1  result consumer accept
res_crc  out  CRC_W  finalised CRC
res_id  out  $clog2(NUM_REQ)  requester that owned the frame
res_beats  out  16  beats in frame, saturating at 16'hFFFF
busy  out  1  state != IDLE

Behaviour:
- One clock, synchronous active-high reset. Reset values: req_ready 0, res_valid 0, res_crc 0, res_id 0, res_beats 0, busy 0, state IDLE, rr_ptr 0, crc_reg INIT.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any req_valid is high, pick the first valid index starting at rr_ptr and wrapping modulo NUM_REQ. Register it as gnt, set crc_reg = INIT and beats = 0, then go to BUSY next cycle. req_ready stays 0 in IDLE.
- BUSY: req_ready[gnt] = 1 combinationally; every other bit is 0. A beat transfers when req_valid[gnt] && req_ready[gnt].
  - On a transfer: crc_reg <= step(crc_reg, data), beats <= sat(beats+1).
  - Bubbles (req_valid[gnt] low) are allowed and do not release the grant, even when other requesters are valid.
- On a transfer with req_last[gnt] = 1:
  - Next cycle: state DONE, res_valid = 1, res_crc = (REFLECT ? reflect(crc_next) : crc_next) ^ XOROUT, res_id = gnt, res_beats = final count.
  - rr_ptr <= (gnt+1) mod NUM_REQ.
- DONE: res_* are held stable while res_valid && !res_ready, and no grant is issued. When res_ready is high, res_valid drops next cycle and state returns to IDLE. This gives a one-cycle arbitration bubble, so the minimum frame turnaround is IDLE + N beats + DONE.
- Latency: from first req_valid in IDLE to first req_ready is 1 cycle. From last-beat acceptance to res_valid is 1 cycle.
- Step function: DATA_W/8 bytes are processed MSB-first per beat, or LSB-first when REFLECT=1. Each byte is bit-serial CRC, unrolled combinationally, and the whole beat completes in one cycle.
- Frames are at least 1 beat; a frame cannot be empty.
- Beat count saturates at 16'hFFFF and the CRC keeps updating.
- A requester dropping req_valid while not granted loses nothing; it is simply skipped.
- Reset during BUSY or DONE: the frame is discarded, there is no partial result, and rr_ptr returns to 0.
- Width rules: the XOR network is exactly CRC_W wide. The res_id width is $clog2(NUM_REQ), with a minimum of 1.

Decomposition:
- Package cl_crc_hw_pkg:
  - state enum (IDLE/BUSY/DONE)
  - CRC-32 IEEE constants (POLY, INIT, XOROUT, check value 32'hCBF43926)
  - reflect() function
- Sub-module cl_crc_step: combinational `crc_out = f(crc_in, data)`, parameterised by DATA_W, CRC_W, POLY and REFLECT. It is instantiated once, so verification can also test it standalone.
- Arbitration, FSM and result register live in cl_crc_arbiter.

Test Plan:
- Requester 0 sends ASCII "123456789" (9 beats, last on '9'), res_ready=1 -> res_crc 32'hCBF43926, res_id 0, res_beats 9; res_valid for one cycle.
- Requester 2 sends the single byte 8'h00 with last -> res_crc 32'hD202EF8D, res_beats 1, req_ready[2] high exactly 1 cycle.
- All 4 requesters hold 1-beat frames continuously -> res_id sequence 0,1,2,3,0,1; never more than one req_ready bit set.
- Requester 1 is mid-frame and drops valid for 3 cycles while requester 3 is valid -> grant stays on 1; the next result is id 1 with the correct CRC, then id 3.
- Hold res_ready=0 for 5 cycles after a result -> res_* stable, req_ready all 0, busy=1; result consumed on cycle 6, next grant issued 2 cycles later.
- Assert rst for 1 cycle after 4 beats of a requester-3 frame -> all outputs 0 next cycle, no result for the aborted frame; requester 3 then resends "123456789" -> 32'hCBF43926.
